// File: rtl/bch_err_apply_p32.sv
// bch_err_apply_p32 -- buffers one BCH codeword (N_WORDS x 32 bits), captures
// the error locations from the Chien search, then streams the codeword back
// out with the located bits flipped.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   in_valid/in_data/in_ready  raw codeword words, word 0 first
//   loc_valid/loc_ready        one location set per codeword
//   aadd1..aadd8, serr         error bit addresses (8191 = empty) and count
//   out_valid/out_data/out_last/out_ready  corrected words, last = word N_WORDS-1
//   corr_cnt, addr_err         per-codeword correction count and address error flag
//
// state     | meaning
// S_IDLE    | empty, accepting words and locations
// S_COLLECT | codeword and/or location set partially captured
// S_DRAIN   | streaming corrected words out
module bch_err_apply_p32 #(
  parameter int N_WORDS = 132
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        loc_valid,
  input  logic [12:0] aadd1,
  input  logic [12:0] aadd2,
  input  logic [12:0] aadd3,
  input  logic [12:0] aadd4,
  input  logic [12:0] aadd5,
  input  logic [12:0] aadd6,
  input  logic [12:0] aadd7,
  input  logic [12:0] aadd8,
  input  logic [3:0]  serr,
  output logic        loc_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [3:0]  corr_cnt,
  output logic        addr_err
);

  localparam logic [7:0]  LP_NW    = 8'(N_WORDS);
  localparam logic [7:0]  LP_LAST  = 8'(N_WORDS - 1);
  localparam logic [12:0] LP_EMPTY = 13'h1FFF;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_alive;
  logic        r_fill_done, r_loc_done;
  logic [7:0]  r_wr_ptr, r_rd_ptr;
  logic [31:0] r_buf [N_WORDS];
  logic [12:0] r_slot_addr [8];
  logic [7:0]  r_slot_vld;
  logic [3:0]  r_corr_cnt;
  logic        r_addr_err;

  logic [12:0] w_aadd [8];
  logic        w_wr, w_cap, w_rd, w_last_hs;
  logic        w_fill_nxt, w_loc_nxt;
  logic [3:0]  w_serr_eff;
  logic [7:0]  w_use;
  logic [3:0]  w_cnt;
  logic        w_err;
  logic [31:0] w_mask;

  assign w_aadd[0] = aadd1;
  assign w_aadd[1] = aadd2;
  assign w_aadd[2] = aadd3;
  assign w_aadd[3] = aadd4;
  assign w_aadd[4] = aadd5;
  assign w_aadd[5] = aadd6;
  assign w_aadd[6] = aadd7;
  assign w_aadd[7] = aadd8;

  // r_alive keeps both ready outputs low while reset is asserted
  assign in_ready  = r_alive & (r_state != S_DRAIN) & ~r_fill_done;
  assign loc_ready = r_alive & (r_state != S_DRAIN) & ~r_loc_done;
  assign out_valid = (r_state == S_DRAIN);

  assign w_wr       = in_valid & in_ready;
  assign w_cap      = loc_valid & loc_ready;
  assign w_rd       = out_valid & out_ready;
  assign w_last_hs  = w_rd & (r_rd_ptr == LP_LAST);
  assign w_fill_nxt = r_fill_done | (w_wr & (r_wr_ptr == LP_LAST));
  assign w_loc_nxt  = r_loc_done | w_cap;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fill_nxt && w_loc_nxt) w_state_nxt = S_DRAIN;
        else if (w_wr || w_cap)      w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_fill_nxt && w_loc_nxt) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Slot qualification at capture time: serr above 8 is clamped (and flagged),
  // empty slots are skipped silently, out-of-range words are dropped and flagged.
  always_comb begin
    w_serr_eff = (serr > 4'd8) ? 4'd8 : serr;
    w_use      = '0;
    w_cnt      = '0;
    w_err      = (serr > 4'd8);
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) < w_serr_eff) && (w_aadd[i] != LP_EMPTY)) begin
        if (w_aadd[i][12:5] < LP_NW) begin
          w_use[i] = 1'b1;
          w_cnt    = w_cnt + 4'd1;
        end else begin
          w_err = 1'b1;
        end
      end
    end
  end

  // XOR accumulation makes duplicate addresses cancel pairwise
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_slot_vld[i] && (r_slot_addr[i][12:5] == r_rd_ptr))
        w_mask = w_mask ^ (32'h1 << r_slot_addr[i][4:0]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_alive     <= 1'b0;
      r_fill_done <= 1'b0;
      r_loc_done  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_slot_vld  <= '0;
      r_corr_cnt  <= '0;
      r_addr_err  <= 1'b0;
      for (int i = 0; i < 8; i++) r_slot_addr[i] <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_last_hs) begin
        r_fill_done <= 1'b0;
        r_loc_done  <= 1'b0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_slot_vld  <= '0;
        r_corr_cnt  <= '0;
        r_addr_err  <= 1'b0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 8'd1;
          if (r_wr_ptr == LP_LAST) r_fill_done <= 1'b1;
        end
        if (w_cap) begin
          r_loc_done <= 1'b1;
          r_slot_vld <= w_use;
          r_corr_cnt <= w_cnt;
          r_addr_err <= w_err;
          for (int i = 0; i < 8; i++) r_slot_addr[i] <= w_aadd[i];
        end
        if (w_rd) r_rd_ptr <= r_rd_ptr + 8'd1;
      end
    end
  end

  // Codeword storage carries no reset; pointers alone define its validity
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_wr_ptr] <= in_data;
  end

  assign out_data = out_valid ? (r_buf[r_rd_ptr] ^ w_mask) : 32'h0;
  assign out_last = out_valid & (r_rd_ptr == LP_LAST);
  assign corr_cnt = r_corr_cnt;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_bch_err_apply_p32.sv
module tb_bch_err_apply_p32;

  localparam int NW = 132;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        loc_valid;
  logic [12:0] aadd [8];
  logic [3:0]  serr;
  logic        loc_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic [3:0]  corr_cnt;
  logic        addr_err;

  logic [31:0] tb_data  [NW];
  logic [31:0] got_data [NW];
  logic        got_last [NW];

  int n_vec;
  int n_err;

  bch_err_apply_p32 #(.N_WORDS(NW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .loc_valid (loc_valid),
    .aadd1     (aadd[0]),
    .aadd2     (aadd[1]),
    .aadd3     (aadd[2]),
    .aadd4     (aadd[3]),
    .aadd5     (aadd[4]),
    .aadd6     (aadd[5]),
    .aadd7     (aadd[6]),
    .aadd8     (aadd[7]),
    .serr      (serr),
    .loc_ready (loc_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .corr_cnt  (corr_cnt),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus drivers (called at a falling edge) ----------------
  task automatic clear_addrs();
    for (int k = 0; k < 8; k++) aadd[k] = 13'h1FFF;
  endtask

  task automatic feed_range(input int lo, input int hi);
    int t;
    for (int i = lo; i < hi; i++) begin
      in_valid = 1'b1;
      in_data  = tb_data[i];
      t = 0;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        n_vec++; n_err++;
        $display("FAIL feed_timeout word %0d: in_ready=%0b required 1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_locs(input logic [3:0] s);
    int t;
    serr = s;
    loc_valid = 1'b1;
    t = 0;
    while (!loc_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!loc_ready) begin
      n_vec++; n_err++;
      $display("FAIL loc_timeout: loc_ready=%0b required 1", loc_ready);
    end
    @(negedge clk);
    loc_valid = 1'b0;
  endtask

  task automatic drain(input int stop_at, output int n);
    int t;
    n = 0;
    t = 0;
    out_ready = 1'b1;
    while (n < stop_at && t < 1000) begin
      if (out_valid) begin
        got_data[n] = out_data;
        got_last[n] = out_last;
        n++;
      end
      @(negedge clk);
      t++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    in_valid = 1'b0; in_data = '0; loc_valid = 1'b0; serr = '0; out_ready = 1'b0;
    clear_addrs();
    #3;
    n_vec++;
    if ({in_ready, loc_ready, out_valid, out_last} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctl: rdy/lrdy/ov/last=%b required 0000", {in_ready, loc_ready, out_valid, out_last});
    end
    n_vec++;
    if ({out_data, corr_cnt, addr_err} !== 37'h0) begin
      n_err++;
      $display("FAIL reset_data: data=%h cnt=%0d err=%0b required all 0", out_data, corr_cnt, addr_err);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({in_ready, loc_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_release: in_ready/loc_ready=%b required 11", {in_ready, loc_ready});
    end
  endtask

  task automatic test_passthrough();
    int n;
    for (int i = 0; i < NW; i++) tb_data[i] = 32'h0;
    clear_addrs();
    feed_range(0, NW);
    send_locs(4'd0);
    n_vec++;
    if ({out_valid, corr_cnt, addr_err} !== 6'b1_0000_0) begin
      n_err++;
      $display("FAIL pass_status: ov=%0b cnt=%0d err=%0b required 1/0/0", out_valid, corr_cnt, addr_err);
    end
    drain(NW, n);
    n_vec++;
    if (n !== NW) begin n_err++; $display("FAIL pass_count: got %0d words required %0d", n, NW); end
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (got_data[i] !== 32'h0 || got_last[i] !== (i == NW - 1)) begin
        n_err++;
        $display("FAIL pass_word%0d: data=%h last=%0b required 00000000/%0b", i, got_data[i], got_last[i], i == NW - 1);
      end
    end
    n_vec++;
    if ({in_ready, loc_ready, out_valid, corr_cnt} !== 7'b110_0000) begin
      n_err++;
      $display("FAIL pass_idle: rdy/lrdy/ov=%b cnt=%0d required 110/0", {in_ready, loc_ready, out_valid}, corr_cnt);
    end
  endtask

  task automatic test_three_errors();
    int n;
    logic [31:0] exp;
    for (int i = 0; i < NW; i++) tb_data[i] = 32'h0;
    clear_addrs();
    aadd[0] = 13'd0; aadd[1] = 13'd37; aadd[2] = 13'd4223;
    feed_range(0, NW);
    send_locs(4'd3);
    n_vec++;
    if (corr_cnt !== 4'd3 || addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL three_cnt: cnt=%0d err=%0b required 3/0", corr_cnt, addr_err);
    end
    drain(NW, n);
    n_vec++;
    if (n !== NW) begin n_err++; $display("FAIL three_count: got %0d words required %0d", n, NW); end
    for (int i = 0; i < n; i++) begin
      exp = (i == 0) ? 32'h0000_0001 : (i == 1) ? 32'h0000_0020 : (i == 131) ? 32'h8000_0000 : 32'h0;
      n_vec++;
      if (got_data[i] !== exp) begin
        n_err++;
        $display("FAIL three_word%0d: data=%h required %h", i, got_data[i], exp);
      end
    end
  endtask

  task automatic test_loc_first();
    int n;
    logic [31:0] exp;
    for (int i = 0; i < NW; i++) tb_data[i] = 32'h0;
    tb_data[2] = 32'hFFFF_FFFF;
    clear_addrs();
    aadd[0] = 13'd64; aadd[1] = 13'd65;   // slot 2 lies beyond serr=1
    send_locs(4'd1);
    n_vec++;
    if ({in_ready, loc_ready, out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL locfirst_capture: rdy/lrdy/ov=%b required 100", {in_ready, loc_ready, out_valid});
    end
    // a second location set while loc_ready=0 must be ignored
    aadd[0] = 13'd0; serr = 4'd2;
    loc_valid = 1'b1;
    @(negedge clk);
    loc_valid = 1'b0;
    feed_range(0, NW - 1);
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL locfirst_wait: rdy/ov=%b required 10 before word 131", {in_ready, out_valid});
    end
    feed_range(NW - 1, NW);
    n_vec++;
    if ({out_valid, in_ready, corr_cnt} !== 6'b10_0001) begin
      n_err++;
      $display("FAIL locfirst_drain: ov/rdy=%b cnt=%0d required 10/1", {out_valid, in_ready}, corr_cnt);
    end
    drain(NW, n);
    n_vec++;
    if (n !== NW) begin n_err++; $display("FAIL locfirst_count: got %0d words required %0d", n, NW); end
    for (int i = 0; i < n; i++) begin
      exp = (i == 2) ? 32'hFFFF_FFFE : 32'h0;
      n_vec++;
      if (got_data[i] !== exp) begin
        n_err++;
        $display("FAIL locfirst_word%0d: data=%h required %h", i, got_data[i], exp);
      end
    end
  endtask

  task automatic test_duplicate();
    int n;
    for (int i = 0; i < NW; i++) tb_data[i] = 32'h0;
    clear_addrs();
    aadd[0] = 13'd100; aadd[1] = 13'd100;
    feed_range(0, NW);
    send_locs(4'd2);
    n_vec++;
    if (corr_cnt !== 4'd2 || addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL dup_cnt: cnt=%0d err=%0b required 2/0", corr_cnt, addr_err);
    end
    drain(NW, n);
    n_vec++;
    if (n !== NW) begin n_err++; $display("FAIL dup_count: got %0d words required %0d", n, NW); end
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (got_data[i] !== 32'h0) begin
        n_err++;
        $display("FAIL dup_word%0d: data=%h required 00000000", i, got_data[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    int n;
    logic [31:0] exp;
    for (int i = 0; i < NW; i++) tb_data[i] = 32'h0;
    clear_addrs();
    aadd[0] = 13'd5000; aadd[1] = 13'd200;   // word 156 (dropped), word 6 bit 8
    feed_range(0, NW);
    send_locs(4'd2);
    n_vec++;
    if (corr_cnt !== 4'd1 || addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL oor_status: cnt=%0d err=%0b required 1/1", corr_cnt, addr_err);
    end
    drain(NW - 1, n);
    n_vec++;
    if (addr_err !== 1'b1 || corr_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL oor_held: cnt=%0d err=%0b required 1/1 before last word", corr_cnt, addr_err);
    end
    @(negedge clk);   // last word handshakes on the edge before this one
    n_vec++;
    if (addr_err !== 1'b0 || corr_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL oor_clear: cnt=%0d err=%0b required 0/0 after codeword", corr_cnt, addr_err);
    end
    for (int i = 0; i < n; i++) begin
      exp = (i == 6) ? 32'h0000_0100 : 32'h0;
      n_vec++;
      if (got_data[i] !== exp) begin
        n_err++;
        $display("FAIL oor_word%0d: data=%h required %h", i, got_data[i], exp);
      end
    end
  endtask

  task automatic test_serr_clamp();
    int n;
    logic [31:0] exp;
    for (int i = 0; i < NW; i++) tb_data[i] = 32'h0;
    clear_addrs();
    aadd[0] = 13'd1; aadd[7] = 13'd33;   // word0 bit1, word1 bit1 (slot 8 used after clamp)
    feed_range(0, NW);
    send_locs(4'd15);
    n_vec++;
    if (corr_cnt !== 4'd2 || addr_err !== 1'b1) begin
      n_err++;
      $display("FAIL clamp_status: cnt=%0d err=%0b required 2/1", corr_cnt, addr_err);
    end
    drain(NW, n);
    n_vec++;
    if (n !== NW) begin n_err++; $display("FAIL clamp_count: got %0d words required %0d", n, NW); end
    for (int i = 0; i < n; i++) begin
      exp = (i < 2) ? 32'h0000_0002 : 32'h0;
      n_vec++;
      if (got_data[i] !== exp) begin
        n_err++;
        $display("FAIL clamp_word%0d: data=%h required %h", i, got_data[i], exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int n, t, k;
    logic have_hold;
    logic [31:0] hold, exp;
    for (int i = 0; i < NW; i++) tb_data[i] = 32'hA500_0000 | 32'(i);
    clear_addrs();
    aadd[0] = 13'd323;   // word 10 bit 3
    out_ready = 1'b0;
    feed_range(0, NW);
    send_locs(4'd1);
    n = 0; t = 0; k = 0; have_hold = 1'b0; hold = '0;
    while (n < NW && t < 2000) begin
      out_ready = (k % 2 == 0);
      k++;
      if (out_valid) begin
        if (have_hold) begin
          n_vec++;
          if (out_data !== hold) begin
            n_err++;
            $display("FAIL bp_stable word%0d: data=%h required %h", n, out_data, hold);
          end
          have_hold = 1'b0;
        end
        if (out_ready) begin
          got_data[n] = out_data;
          got_last[n] = out_last;
          n++;
        end else begin
          hold = out_data;
          have_hold = 1'b1;
        end
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b1;
    n_vec++;
    if (n !== NW) begin n_err++; $display("FAIL bp_count: got %0d words required %0d", n, NW); end
    for (int i = 0; i < n; i++) begin
      exp = (i == 10) ? 32'hA500_0002 : (32'hA500_0000 | 32'(i));
      n_vec++;
      if (got_data[i] !== exp || got_last[i] !== (i == NW - 1)) begin
        n_err++;
        $display("FAIL bp_word%0d: data=%h last=%0b required %h/%0b", i, got_data[i], got_last[i], exp, i == NW - 1);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    logic [31:0] exp;
    for (int i = 0; i < NW; i++) tb_data[i] = 32'h5A5A_0000;
    clear_addrs();
    aadd[0] = 13'd7;
    feed_range(0, NW);
    send_locs(4'd1);
    drain(60, n);
    n_vec++;
    if (n !== 60) begin n_err++; $display("FAIL rst_drain_count: got %0d words required 60", n); end
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, loc_ready, out_valid, out_last, out_data, corr_cnt, addr_err} !== 41'h0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: rdy/lrdy/ov/last=%b data=%h cnt=%0d err=%0b required all 0",
               {in_ready, loc_ready, out_valid, out_last}, out_data, corr_cnt, addr_err);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NW; i++) tb_data[i] = 32'(i);
    clear_addrs();
    aadd[0] = 13'd160;   // word 5 bit 0
    feed_range(0, NW);
    send_locs(4'd1);
    n_vec++;
    if (corr_cnt !== 4'd1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_next_status: cnt=%0d ov=%0b required 1/1", corr_cnt, out_valid);
    end
    drain(NW, n);
    n_vec++;
    if (n !== NW) begin n_err++; $display("FAIL rst_next_count: got %0d words required %0d", n, NW); end
    for (int i = 0; i < n; i++) begin
      exp = (i == 5) ? 32'd4 : 32'(i);
      n_vec++;
      if (got_data[i] !== exp) begin
        n_err++;
        $display("FAIL rst_next_word%0d: data=%h required %h", i, got_data[i], exp);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_passthrough();
    test_three_errors();
    test_loc_first();
    test_duplicate();
    test_out_of_range();
    test_serr_clamp();
    test_backpressure();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
